// File: rtl/npu_i2c_pkg.sv
// Shared types and constants for the single-byte I2C master engine.
// The START/STOP line patterns are indexed by the quarter number (bit 0 = q0).
package npu_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_DATA,
    ST_ACK_D,
    ST_STOP
  } state_t;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  localparam int QCNT_W = 16;
  localparam int BIT_W  = 3;

  localparam logic [3:0] START_SDA = 4'b0001;
  localparam logic [3:0] START_SCL = 4'b0111;
  localparam logic [3:0] STOP_SDA  = 4'b1000;
  localparam logic [3:0] STOP_SCL  = 4'b1110;

endpackage

// File: rtl/npu_i2c_tick.sv
// Quarter-period divider: pulses tick on the last cycle of each quarter and
// tracks the 2-bit quarter index within the current bit cell.
module npu_i2c_tick
  import npu_i2c_pkg::*;
#(
  parameter int QUARTER = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic       tick,
  output logic [1:0] qidx
);

  localparam logic [QCNT_W-1:0] CNT_LAST = QCNT_W'(QUARTER - 1);

  logic [QCNT_W-1:0] cnt_reg;
  logic [1:0]        qidx_reg;

  assign tick = en && (cnt_reg == CNT_LAST);
  assign qidx = qidx_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      qidx_reg <= 2'd0;
    end else if (clear) begin
      cnt_reg  <= '0;
      qidx_reg <= 2'd0;
    end else if (en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg  <= '0;
        qidx_reg <= qidx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/npu_i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Bus lines are registered from the current state, so the pins trail the FSM by one cycle.
module npu_i2c_master
  import npu_i2c_pkg::*;
#(
  parameter int QUARTER = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       SDA_in,
  output logic       SDA,
  output logic       SCL
);

  if (QUARTER < 2 || QUARTER > (1 << QCNT_W)) begin : g_quarter_check
    $error("npu_i2c_master: QUARTER out of range");
  end

  state_t             state_reg, state_next;
  logic               accept, tick, bit_end, last_bit;
  logic               fin_next, scl_next, sda_next;
  logic [1:0]         qidx;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [7:0]         shift_reg, wdata_reg;
  logic               rw_reg, nack_reg, fin_reg;
  logic               sda_meta_reg, sda_sync_reg;

  assign accept   = cmd_valid && cmd_ready;
  assign busy     = ~cmd_ready;
  assign bit_end  = tick && (qidx == 2'd3);
  assign last_bit = (bit_cnt_reg == BIT_W'(7));

  npu_i2c_tick #(.QUARTER(QUARTER)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .en    (state_reg != ST_IDLE),
    .tick  (tick),
    .qidx  (qidx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    scl_next   = 1'b1;
    sda_next   = 1'b1;
    fin_next   = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_START;
      ST_START: begin
        sda_next = START_SDA[qidx];
        scl_next = START_SCL[qidx];
        if (bit_end) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        sda_next = shift_reg[7];
        scl_next = qidx[1];
        if (bit_end && last_bit) state_next = ST_ACK_A;
      end
      ST_ACK_A: begin
        scl_next = qidx[1];
        // An address NACK skips the data phase entirely.
        if (bit_end) state_next = sda_sync_reg ? ST_STOP : ST_DATA;
      end
      ST_DATA: begin
        sda_next = (rw_reg == I2C_READ) ? 1'b1 : shift_reg[7];
        scl_next = qidx[1];
        if (bit_end && last_bit) state_next = ST_ACK_D;
      end
      ST_ACK_D: begin
        scl_next = qidx[1];
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        sda_next = STOP_SDA[qidx];
        scl_next = STOP_SCL[qidx];
        if (bit_end) begin
          state_next = ST_IDLE;
          fin_next   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      SCL          <= 1'b1;
      SDA          <= 1'b1;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      rsp_nack     <= 1'b0;
      fin_reg      <= 1'b0;
      rw_reg       <= I2C_WRITE;
      wdata_reg    <= 8'h00;
      shift_reg    <= 8'h00;
      bit_cnt_reg  <= '0;
      nack_reg     <= 1'b0;
    end else begin
      sda_meta_reg <= SDA_in;
      sda_sync_reg <= sda_meta_reg;
      SCL          <= scl_next;
      SDA          <= sda_next;
      fin_reg      <= fin_next;
      rsp_valid    <= fin_reg;
      if (accept) begin
        cmd_ready   <= 1'b0;
        rw_reg      <= cmd_rw;
        wdata_reg   <= cmd_wdata;
        shift_reg   <= {cmd_addr, cmd_rw};
        bit_cnt_reg <= '0;
        nack_reg    <= 1'b0;
      end else if (fin_reg) begin
        // Response cycle: engine becomes idle together with rsp_valid.
        cmd_ready <= 1'b1;
        rsp_nack  <= nack_reg;
        if (rw_reg == I2C_READ && !nack_reg) rsp_rdata <= shift_reg;
      end
      if (bit_end) begin
        case (state_reg)
          ST_ADDR: begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            shift_reg   <= (last_bit && rw_reg == I2C_WRITE) ? wdata_reg
                                                             : {shift_reg[6:0], sda_sync_reg};
          end
          ST_DATA: begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            shift_reg   <= {shift_reg[6:0], sda_sync_reg};
          end
          ST_ACK_A: if (sda_sync_reg) nack_reg <= 1'b1;
          ST_ACK_D: if (rw_reg == I2C_WRITE && sda_sync_reg) nack_reg <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_i2c_master.sv
// Directed bench for npu_i2c_master with a bus-level I2C slave model on a
// wired-AND SDA line; each scenario task checks its own expected values.
module tb_npu_i2c_master;

  localparam int Q = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_nack, busy, SDA, SCL;
  logic [7:0] rsp_rdata;
  logic       slv_sda = 1'b1;
  logic       bus_sda;

  int checks = 0;
  int errors = 0;

  assign bus_sda = SDA & slv_sda;

  npu_i2c_master #(.QUARTER(Q)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .SDA_in    (bus_sda),
    .SDA       (SDA),
    .SCL       (SCL)
  );

  always #5 clock = ~clock;

  // Slave model, sampled on the falling system clock edge.
  logic       slv_ack_addr = 1'b1;
  logic       slv_ack_data = 1'b1;
  logic [7:0] slv_rdata = 8'h00;
  int         start_cnt = 0, stop_cnt = 0, rises = 0, bitn = 0, byten = 0;
  logic [7:0] by0 = 8'h00, by1 = 8'h00, shr = 8'h00;
  logic       ak0 = 1'b1, ak1 = 1'b1, addr_acked = 1'b0;
  logic       p_scl = 1'b1, p_sda = 1'b1;

  always @(negedge clock) begin
    if (p_scl && SCL && p_sda && !bus_sda) begin
      start_cnt++; bitn = 0; byten = 0; rises = 0; addr_acked = 1'b0;
      slv_sda = 1'b1; by0 = 8'h00; by1 = 8'h00; ak0 = 1'b1; ak1 = 1'b1;
    end else if (p_scl && SCL && !p_sda && bus_sda) begin
      stop_cnt++;
    end else if (!p_scl && SCL) begin
      rises++;
      if (bitn < 8) begin
        shr = {shr[6:0], bus_sda};
        bitn++;
        if (bitn == 8) begin
          if (byten == 0) by0 = shr;
          else if (byten == 1) by1 = shr;
        end
      end else begin
        if (byten == 0) begin ak0 = bus_sda; addr_acked = !bus_sda; end
        else if (byten == 1) ak1 = bus_sda;
        bitn = 0;
        byten++;
      end
    end else if (p_scl && !SCL) begin
      slv_sda = 1'b1;
      if (bitn == 8 && byten == 0 && slv_ack_addr) slv_sda = 1'b0;
      else if (bitn == 8 && byten == 1 && !by0[0] && slv_ack_data) slv_sda = 1'b0;
      else if (bitn < 8 && byten == 1 && by0[0] && addr_acked) slv_sda = slv_rdata[7-bitn];
    end
    p_scl = SCL;
    p_sda = bus_sda;
  end

  task automatic accept_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d,
                            output bit ok);
    int n;
    ok = 1'b0; n = 0;
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!ok && n < 2000) begin
      if (cmd_ready) ok = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int rdy);
    int n;
    bit done;
    n = 0; done = 1'b0; rdy = 0; lat = -1;
    while (!done && n < 2000) begin
      @(posedge clock); #1;
      n++;
      if (rsp_valid) begin lat = n; done = 1'b1; end
      else if (cmd_ready) rdy++;
    end
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d,
                         output int lat, output int rdy);
    bit ok;
    lat = -1; rdy = 0;
    accept_cmd(rw, a, d, ok);
    if (ok) wait_rsp(lat, rdy);
    $display("txn rw=%0d addr=%02h wdata=%02h lat=%0d nack=%0b rdata=%02h bus=%02h/%02h",
             rw, a, d, lat, rsp_nack, rsp_rdata, by0, by1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (SCL !== 1'b1) begin errors++; $display("FAIL reset_scl got %b want 1", SCL); end
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", SDA); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %02h want 00", rsp_rdata); end
    checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL reset_nack got %b want 0", rsp_nack); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write_ack();
    int lat, rdy, s0, p0;
    slv_ack_addr = 1'b1; slv_ack_data = 1'b1;
    s0 = start_cnt; p0 = stop_cnt;
    run_cmd(1'b0, 7'h50, 8'h5A, lat, rdy);
    checks++; if (lat !== 321) begin errors++; $display("FAIL wr_latency got %0d want 321", lat); end
    checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL wr_nack got %b want 0", rsp_nack); end
    checks++; if (by0 !== 8'hA0) begin errors++; $display("FAIL wr_addr_byte got %02h want a0", by0); end
    checks++; if (by1 !== 8'h5A) begin errors++; $display("FAIL wr_data_byte got %02h want 5a", by1); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL wr_start got %0d want 1", start_cnt - s0); end
    checks++; if (stop_cnt - p0 !== 1) begin errors++; $display("FAIL wr_stop got %0d want 1", stop_cnt - p0); end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL wr_ready_while_busy got %0d want 0", rdy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_at_rsp got %b want 1", cmd_ready); end
  endtask

  task automatic test_read();
    int lat, rdy;
    slv_ack_addr = 1'b1; slv_rdata = 8'h3C;
    run_cmd(1'b1, 7'h50, 8'hFF, lat, rdy);
    checks++; if (lat !== 321) begin errors++; $display("FAIL rd_latency got %0d want 321", lat); end
    checks++; if (by0 !== 8'hA1) begin errors++; $display("FAIL rd_addr_byte got %02h want a1", by0); end
    checks++; if (ak1 !== 1'b1) begin errors++; $display("FAIL rd_master_nack got %b want 1", ak1); end
    checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL rd_rdata got %02h want 3c", rsp_rdata); end
    checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL rd_nack got %b want 0", rsp_nack); end
  endtask

  task automatic test_no_slave();
    int lat, rdy, p0;
    slv_ack_addr = 1'b0; p0 = stop_cnt;
    run_cmd(1'b1, 7'h50, 8'h00, lat, rdy);
    checks++; if (lat !== 44*Q+1) begin errors++; $display("FAIL ns_latency got %0d want %0d", lat, 44*Q+1); end
    checks++; if (rsp_nack !== 1'b1) begin errors++; $display("FAIL ns_nack got %b want 1", rsp_nack); end
    checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL ns_rdata_held got %02h want 3c", rsp_rdata); end
    checks++; if (rises !== 10) begin errors++; $display("FAIL ns_scl_pulses got %0d want 10", rises); end
    checks++; if (stop_cnt - p0 !== 1) begin errors++; $display("FAIL ns_stop got %0d want 1", stop_cnt - p0); end
  endtask

  task automatic test_data_nack();
    int lat, rdy, p0;
    slv_ack_addr = 1'b1; slv_ack_data = 1'b0; p0 = stop_cnt;
    run_cmd(1'b0, 7'h51, 8'hC3, lat, rdy);
    checks++; if (lat !== 80*Q+1) begin errors++; $display("FAIL dn_latency got %0d want %0d", lat, 80*Q+1); end
    checks++; if (rsp_nack !== 1'b1) begin errors++; $display("FAIL dn_nack got %b want 1", rsp_nack); end
    checks++; if (by0 !== 8'hA2) begin errors++; $display("FAIL dn_addr_byte got %02h want a2", by0); end
    checks++; if (by1 !== 8'hC3) begin errors++; $display("FAIL dn_data_byte got %02h want c3", by1); end
    checks++; if (stop_cnt - p0 !== 1) begin errors++; $display("FAIL dn_stop got %0d want 1", stop_cnt - p0); end
    checks++; if (rsp_rdata !== 8'h3C) begin errors++; $display("FAIL dn_rdata_held got %02h want 3c", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int lat, rdy, s0;
    slv_ack_addr = 1'b1; slv_ack_data = 1'b1; slv_rdata = 8'h96;
    s0 = start_cnt;
    cmd_rw = 1'b0; cmd_addr = 7'h50; cmd_wdata = 8'h11; cmd_valid = 1'b1;
    @(posedge clock); #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_first_accept got ready=%b want 0", cmd_ready); end
    wait_rsp(lat, rdy);
    $display("txn rw=0 addr=50 wdata=11 lat=%0d nack=%0b bus=%02h/%02h", lat, rsp_nack, by0, by1);
    checks++; if (lat !== 321) begin errors++; $display("FAIL b2b_first_latency got %0d want 321", lat); end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL b2b_accept_midtxn got %0d want 0", rdy); end
    checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL b2b_first_nack got %b want 0", rsp_nack); end
    checks++; if (by1 !== 8'h11) begin errors++; $display("FAIL b2b_first_data got %02h want 11", by1); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_rsp got %b want 1", cmd_ready); end
    cmd_rw = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got ready=%b want 0", cmd_ready); end
    wait_rsp(lat, rdy);
    $display("txn rw=1 addr=50 lat=%0d nack=%0b rdata=%02h", lat, rsp_nack, rsp_rdata);
    checks++; if (lat !== 321) begin errors++; $display("FAIL b2b_second_latency got %0d want 321", lat); end
    checks++; if (rsp_rdata !== 8'h96) begin errors++; $display("FAIL b2b_second_rdata got %02h want 96", rsp_rdata); end
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL b2b_starts got %0d want 2", start_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat, rdy, pulses;
    slv_ack_addr = 1'b1; slv_ack_data = 1'b1;
    accept_cmd(1'b0, 7'h50, 8'h00, ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy got %b want 1 (accept ok=%0d)", busy, ok); end
    repeat (194) @(posedge clock);
    #1;
    checks++; if (SCL !== 1'b0) begin errors++; $display("FAIL rm_pre_scl got %b want 0", SCL); end
    checks++; if (SDA !== 1'b0) begin errors++; $display("FAIL rm_pre_sda got %b want 0", SDA); end
    #2 reset = 1'b1;
    #1;
    checks++; if (SCL !== 1'b1) begin errors++; $display("FAIL rm_scl got %b want 1", SCL); end
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL rm_sda got %b want 1", SDA); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_clr got %b want 0", busy); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rm_no_rsp got %0d want 0", pulses); end
    run_cmd(1'b0, 7'h50, 8'h77, lat, rdy);
    checks++; if (lat !== 321) begin errors++; $display("FAIL rm_next_latency got %0d want 321", lat); end
    checks++; if (by1 !== 8'h77) begin errors++; $display("FAIL rm_next_data got %02h want 77", by1); end
    checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL rm_next_nack got %b want 0", rsp_nack); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_ack();
    test_read();
    test_no_slave();
    test_data_nack();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
